// File: rtl/averager_pkg.sv
// -----------------------------------------------------------------------------
// averager_pkg
// Shared definitions for the averager sequencer slice:
//   seq_state_t    - sequencer FSM state encoding
//   COUNT_MAX_RST  - reset value of the frame-length output (all ones; sliced
//                    to FAST_COUNT_WIDTH by the user)
//   clamp_target   - maps a requested frame target of 0 to 1
// -----------------------------------------------------------------------------
package averager_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_FRAMES = 3'd1,
      ST_RESTART     = 3'd2,
      ST_WAIT_BUSY   = 3'd3,
      ST_WAIT_READY  = 3'd4,
      ST_DONE        = 3'd5
   } seq_state_t;

   // Wide enough for any sensible FAST_COUNT_WIDTH; users take the low bits.
   localparam logic [63:0] COUNT_MAX_RST = '1;

   // A target of zero frames would never complete, so it is run as one frame.
   function automatic logic [63:0] clamp_target(input logic [63:0] n);
      return (n == 64'd0) ? 64'd1 : n;
   endfunction

endpackage

// File: rtl/averager_frame_counter.sv
// -----------------------------------------------------------------------------
// averager_frame_counter
// Counts enabled sample strobes modulo (count_max+1); every wrap completes one
// frame. 'reached' is asserted combinationally on the strobe that completes
// frame number 'target' (target is assumed >= 1).
// Ports:
//   clk       - clock, rising edge
//   resetn    - asynchronous active-low reset, clears both counters
//   clear     - synchronous clear of both counters
//   en        - sample strobe to count
//   count_max - frame length minus 1
//   target    - number of frames to count
//   reached   - high on the strobe that completes the last frame
// -----------------------------------------------------------------------------
module averager_frame_counter #(
   parameter int FAST_COUNT_WIDTH = 13,
   parameter int SLOW_COUNT_WIDTH = 19
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        clear,
   input  logic                        en,
   input  logic [FAST_COUNT_WIDTH-1:0] count_max,
   input  logic [SLOW_COUNT_WIDTH-1:0] target,
   output logic                        reached
);

   logic [FAST_COUNT_WIDTH-1:0] r_fast;
   logic [SLOW_COUNT_WIDTH-1:0] r_frames;
   logic                        w_wrap;
   logic [SLOW_COUNT_WIDTH-1:0] w_frames_inc;

   assign w_wrap       = en && (r_fast == count_max);
   assign w_frames_inc = r_frames + SLOW_COUNT_WIDTH'(1);
   // The wrapping strobe of the last frame: frames already done == target-1.
   assign reached      = w_wrap && (w_frames_inc == target);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fast   <= '0;
         r_frames <= '0;
      end else if (clear) begin
         r_fast   <= '0;
         r_frames <= '0;
      end else if (en) begin
         if (w_wrap) begin
            r_fast   <= '0;
            r_frames <= w_frames_inc;
         end else begin
            r_fast   <= r_fast + FAST_COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/averager_sequencer.sv
// -----------------------------------------------------------------------------
// averager_sequencer
// Sequences an averaging acquisition: waits for a programmed number of frames
// of ADC samples, pulses restart to the averager counter, waits for the counter
// to go busy (ready low) and then ready again, captures its average count and
// reports completion. Optionally re-arms after each completion.
//
// Ports:
//   clk, resetn        - clock (rising edge), asynchronous active-low reset
//   start              - one-cycle pulse, acted on only in IDLE
//   stop               - level abort back to IDLE, highest priority
//   continuous         - re-arm automatically after each DONE
//   n_target           - frames per acquisition (0 treated as 1)
//   count_max_in       - frame length minus 1, latched on start
//   clken_in           - ADC sample-valid strobe
//   ready, n_avg       - status from the averager counter
//   restart            - one-cycle restart pulse to the averager counter
//   clken              - clken_in gated by busy (combinational)
//   count_max          - latched frame length, stable while busy
//   busy, done         - status flags
//   n_avg_last         - n_avg captured at completion
//   run_count          - completed acquisitions, wraps at 2^32
//
// Build option AVERAGER_SEQUENCER_TIMEOUT_EN adds:
//   timeout_cycles     - max cycles for one stay in WAIT_BUSY/WAIT_READY (0 = off)
//   timeout_clr        - clears the sticky timeout flag
//   timeout            - sticky flag, set when a wait exceeded timeout_cycles
// -----------------------------------------------------------------------------
module averager_sequencer
   import averager_pkg::*;
#(
   parameter int FAST_COUNT_WIDTH = 13,
   parameter int SLOW_COUNT_WIDTH = 19
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        continuous,
   input  logic [SLOW_COUNT_WIDTH-1:0] n_target,
   input  logic [FAST_COUNT_WIDTH-1:0] count_max_in,
   input  logic                        clken_in,
   input  logic                        ready,
   input  logic [SLOW_COUNT_WIDTH-1:0] n_avg,
   output logic                        restart,
   output logic                        clken,
   output logic [FAST_COUNT_WIDTH-1:0] count_max,
   output logic                        busy,
   output logic                        done,
   output logic [SLOW_COUNT_WIDTH-1:0] n_avg_last,
   output logic [31:0]                 run_count
`ifdef AVERAGER_SEQUENCER_TIMEOUT_EN
   ,
   input  logic [31:0]                 timeout_cycles,
   input  logic                        timeout_clr,
   output logic                        timeout
`endif
);

   seq_state_t                  r_state;
   logic                        r_restart;
   logic                        r_busy;
   logic                        r_done;
   logic [FAST_COUNT_WIDTH-1:0] r_count_max;
   logic [SLOW_COUNT_WIDTH-1:0] r_target;
   logic [SLOW_COUNT_WIDTH-1:0] r_n_avg_last;
   logic [31:0]                 r_run_count;

   logic                        w_reached;
   logic                        w_frame_clear;
   logic                        w_frame_en;
   logic                        w_timeout_hit;
   logic [SLOW_COUNT_WIDTH-1:0] w_target_clamped;

   assign w_target_clamped = SLOW_COUNT_WIDTH'(clamp_target(64'(n_target)));

   // Frame counters only run in WAIT_FRAMES and are held at zero otherwise,
   // so every entry into WAIT_FRAMES starts from a clean count.
   assign w_frame_clear = (r_state != ST_WAIT_FRAMES);
   assign w_frame_en    = (r_state == ST_WAIT_FRAMES) && clken_in;

   averager_frame_counter #(
      .FAST_COUNT_WIDTH (FAST_COUNT_WIDTH),
      .SLOW_COUNT_WIDTH (SLOW_COUNT_WIDTH)
   ) u_frame_counter (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (w_frame_clear),
      .en        (w_frame_en),
      .count_max (r_count_max),
      .target    (r_target),
      .reached   (w_reached)
   );

`ifdef AVERAGER_SEQUENCER_TIMEOUT_EN
   logic [31:0] r_wait_cnt;
   logic        r_timeout;
   logic        w_in_wait;

   assign w_in_wait     = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_READY);
   // r_wait_cnt holds (cycles already spent in this wait - 1); hitting
   // timeout_cycles means this cycle is one beyond the allowed stay.
   assign w_timeout_hit = w_in_wait && (timeout_cycles != 32'd0) &&
                          (r_wait_cnt == timeout_cycles);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         // Leaving WAIT_BUSY for WAIT_READY starts a fresh stay.
         if (!w_in_wait || ((r_state == ST_WAIT_BUSY) && !ready))
            r_wait_cnt <= '0;
         else
            r_wait_cnt <= r_wait_cnt + 32'd1;

         if (w_timeout_hit && !stop)
            r_timeout <= 1'b1;
         else if (timeout_clr)
            r_timeout <= 1'b0;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_restart    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_count_max  <= COUNT_MAX_RST[FAST_COUNT_WIDTH-1:0];
         r_target     <= SLOW_COUNT_WIDTH'(1);
         r_n_avg_last <= '0;
         r_run_count  <= '0;
      end else begin
         // Pulse outputs default low; only the entering transition raises them.
         r_restart <= 1'b0;
         r_done    <= 1'b0;
         if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_count_max <= count_max_in;
                     r_target    <= w_target_clamped;
                     r_state     <= ST_WAIT_FRAMES;
                     r_busy      <= 1'b1;
                  end
               end
               ST_WAIT_FRAMES: begin
                  if (w_reached) begin
                     r_state   <= ST_RESTART;
                     r_restart <= 1'b1;
                  end
               end
               ST_RESTART: begin
                  r_state <= ST_WAIT_BUSY;
               end
               ST_WAIT_BUSY: begin
                  if (w_timeout_hit) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (!ready) begin
                     r_state <= ST_WAIT_READY;
                  end
               end
               ST_WAIT_READY: begin
                  if (w_timeout_hit) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (ready) begin
                     r_n_avg_last <= n_avg;
                     r_run_count  <= r_run_count + 32'd1;
                     r_state      <= ST_DONE;
                     r_done       <= 1'b1;
                  end
               end
               ST_DONE: begin
                  if (continuous) begin
                     r_state <= ST_WAIT_FRAMES;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign restart    = r_restart;
   assign busy       = r_busy;
   assign done       = r_done;
   assign count_max  = r_count_max;
   assign n_avg_last = r_n_avg_last;
   assign run_count  = r_run_count;
   // Zero-latency gating so the averager sees samples in the same cycle.
   assign clken      = clken_in & r_busy;

endmodule

// File: doc/averager_sequencer.md
AVERAGER_SEQUENCER -- requirements
Module: averager_sequencer

Interface
REQ-001 Parameter FAST_COUNT_WIDTH, default 13, sets the width of the frame-length (fast) counter.
REQ-002 Parameter SLOW_COUNT_WIDTH, default 19, sets the width of the average (slow) counter.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; starts an acquisition; acted on only in IDLE.
REQ-006 stop  input  1  level; aborts the run and returns to IDLE.
REQ-007 continuous  input  1  when 1, each DONE re-arms automatically.
REQ-008 n_target  input  SLOW_COUNT_WIDTH  number of frames to accumulate before restart; 0 is treated as 1.
REQ-009 count_max_in  input  FAST_COUNT_WIDTH  requested frame length minus 1.
REQ-010 clken_in  input  1  sample-valid strobe from the ADC path.
REQ-011 ready  input  1  ready flag from the averager counter.
REQ-012 n_avg  input  SLOW_COUNT_WIDTH  average count from the averager counter.
REQ-013 restart  output  1  one-cycle restart pulse to the averager counter.
REQ-014 clken  output  1  gated sample strobe to the averager counter.
REQ-015 count_max  output  FAST_COUNT_WIDTH  frame length to the averager counter.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  high while in DONE.
REQ-018 n_avg_last  output  SLOW_COUNT_WIDTH  n_avg captured at completion.
REQ-019 run_count  output  32  number of completed acquisitions; wraps modulo 2^32.

Function
REQ-020 The FSM SHALL have these states: IDLE, WAIT_FRAMES, RESTART, WAIT_BUSY, WAIT_READY, DONE.
REQ-021 IDLE + start: latch count_max_in into count_max, latch max(n_target,1), clear frame counters, go to WAIT_FRAMES.
REQ-022 count_max SHALL change only on the IDLE exit edge and SHALL remain stable while busy=1.
REQ-023 clken SHALL equal clken_in while busy=1 and SHALL be 0 in IDLE (zero combinational delay).
REQ-024 WAIT_FRAMES: count clken_in cycles modulo count_max+1; each wrap increments the frame count; when the latched target is reached, go to RESTART.
REQ-025 RESTART lasts exactly 1 cycle with restart=1, then goes to WAIT_BUSY; restart SHALL be 0 in all other states.
REQ-026 WAIT_BUSY: go to WAIT_READY when ready=0.
REQ-027 WAIT_READY: when ready=1, capture n_avg into n_avg_last in the same cycle, increment run_count, and go to DONE.
REQ-028 DONE lasts 1 cycle; go to WAIT_FRAMES (counters cleared) if continuous=1, otherwise to IDLE.
REQ-029 stop=1 in any state SHALL force IDLE on the next edge; stop has priority over all other transitions; n_avg_last and run_count are not updated on stop.
REQ-030 start outside IDLE SHALL be ignored; start and stop in the same cycle resolve to IDLE.

Reset
REQ-031 resetn=0 SHALL asynchronously force: state=IDLE; restart=0, done=0, busy=0, clken=0; n_avg_last=0; run_count=0; count_max all ones; frame counters 0.
REQ-032 Reset deassertion mid-acquisition SHALL NOT emit a restart pulse.

Configuration
REQ-033 With AVERAGER_SEQUENCER_TIMEOUT_EN defined, add a 32-bit port timeout_cycles, a sticky output timeout, and a clear input timeout_clr.
- Any single stay in WAIT_BUSY or WAIT_READY longer than timeout_cycles clock cycles SHALL set timeout and go to IDLE.
- timeout_cycles=0 disables the check.
- timeout_clr or resetn clears timeout.
REQ-034 Without AVERAGER_SEQUENCER_TIMEOUT_EN, these ports and the timeout logic SHALL be absent, and WAIT_BUSY/WAIT_READY wait indefinitely.

Structure
REQ-035 The state enum and the reset value of count_max SHALL live in the shared package averager_pkg.
REQ-036 The frame-counting logic SHALL be one sub-module, averager_frame_counter, with inputs clk, resetn, clear, en, count_max, target and output reached.

Verification
REQ-037 count_max_in=7, n_target=3, clken_in=1, start pulse -> restart asserted exactly once, 24 cycles after start, for 1 cycle.
REQ-038 ready drops 2 cycles after restart and rises later with n_avg=5 -> n_avg_last=5, done high for 1 cycle, run_count=1, then IDLE.
REQ-039 continuous=1, n_target=2, count_max_in=3 -> restart pulses repeat; run_count increments on each DONE.
REQ-040 stop asserted in WAIT_READY -> IDLE next cycle, n_avg_last and run_count unchanged, clken=0.
REQ-041 count_max_in changed while busy -> count_max output unchanged until the next start.
REQ-042 With AVERAGER_SEQUENCER_TIMEOUT_EN, timeout_cycles=10 and ready held at 1 -> timeout=1 after 11 cycles in WAIT_BUSY, state IDLE; timeout_clr clears it.
